// File: rtl/conveyor_sequencer_pkg.sv
// Shared state encodings and parameter defaults for the conveyor station sequencer.
package conveyor_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FEED    = 3'd1,
        S_DWELL   = 3'd2,
        S_RELEASE = 3'd3,
        S_DONE    = 3'd4,
        S_FAULT   = 3'd5
    } state_t;

    localparam logic [15:0] DWELL_CYCLES_DEF = 16'd1000;
    localparam logic [23:0] JAM_CYCLES_DEF   = 24'd50000;
    localparam logic [7:0]  BATCH_DEF        = 8'd10;
    localparam int          CNT_W_DEF        = 8;

    function automatic logic belt_on(state_t s);
        return (s == S_FEED) || (s == S_RELEASE);
    endfunction

endpackage

// File: rtl/conveyor_sequencer_sync_edge.sv
// Two-flop synchronizer for an asynchronous operator/sensor input, with a
// one-cycle pulse on the synchronized rising edge.
module conveyor_sequencer_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic meta;
    logic sync;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta   <= async_in;
            sync   <= meta;
            sync_q <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~sync_q;

endmodule

// File: rtl/conveyor_sequencer.sv
// Conveyor station sequencer: feed, stop at station, dwell, release, count to a
// batch; jam timeout and e-stop drive a latched fault cleared by operator ack.
//
//   state   | meaning
//   IDLE    | belt stopped, waiting for start
//   FEED    | belt running until a piece reaches the station
//   DWELL   | belt stopped, station tool enabled for DWELL_CYCLES
//   RELEASE | belt running until the piece clears the sensor
//   DONE    | batch complete, waiting for start
//   FAULT   | jam or e-stop, waiting for ack with e-stop released
module conveyor_sequencer
    import conveyor_sequencer_pkg::*;
#(
    parameter logic [15:0] DWELL_CYCLES = DWELL_CYCLES_DEF,
    parameter logic [23:0] JAM_CYCLES   = JAM_CYCLES_DEF,
    parameter logic [7:0]  BATCH        = BATCH_DEF,
    parameter int          CNT_W        = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop_req,
    input  logic             estop,
    input  logic             piece_sensor,
    input  logic             fault_ack,
    output logic             belt_run,
    output logic             station_en,
    output logic [CNT_W-1:0] piece_count,
    output logic             batch_done,
    output logic             fault,
    output logic [2:0]       state_dbg
);

    localparam logic [CNT_W-1:0] BATCH_C = CNT_W'(BATCH);

    logic start_lvl, start_rise;
    logic stop_lvl, stop_rise;
    logic estop_lvl, estop_rise;
    logic piece_lvl, piece_rise;
    logic ack_lvl, ack_rise;
    logic unused_sync;

    conveyor_sequencer_sync_edge u_sync_start (.clk(clk), .reset(reset), .async_in(start),
                                               .level(start_lvl), .rise(start_rise));
    conveyor_sequencer_sync_edge u_sync_stop  (.clk(clk), .reset(reset), .async_in(stop_req),
                                               .level(stop_lvl), .rise(stop_rise));
    conveyor_sequencer_sync_edge u_sync_estop (.clk(clk), .reset(reset), .async_in(estop),
                                               .level(estop_lvl), .rise(estop_rise));
    conveyor_sequencer_sync_edge u_sync_piece (.clk(clk), .reset(reset), .async_in(piece_sensor),
                                               .level(piece_lvl), .rise(piece_rise));
    conveyor_sequencer_sync_edge u_sync_ack   (.clk(clk), .reset(reset), .async_in(fault_ack),
                                               .level(ack_lvl), .rise(ack_rise));

    assign unused_sync = start_lvl ^ stop_rise ^ estop_rise ^ ack_rise;

    state_t      state, next_state;
    logic [15:0] dwell_cnt;
    logic [23:0] jam_cnt;
    logic        stop_pending;
    logic        dwell_last;
    logic        jam_hit;
    logic        count_inc;

    assign dwell_last = (dwell_cnt == DWELL_CYCLES - 16'd1);
    assign jam_hit    = (jam_cnt == JAM_CYCLES - 24'd1);

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (start_rise) next_state = S_FEED;
            S_FEED: begin
                if (jam_hit)         next_state = S_FAULT;
                else if (stop_lvl)   next_state = S_IDLE;
                else if (piece_rise) next_state = S_DWELL;
            end
            S_DWELL: begin
                if (dwell_last) begin
                    if (piece_count == BATCH_C - CNT_W'(1)) next_state = S_DONE;
                    else if (stop_pending || stop_lvl)      next_state = S_IDLE;
                    else                                    next_state = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (jam_hit)         next_state = S_FAULT;
                else if (stop_lvl)   next_state = S_IDLE;
                else if (!piece_lvl) next_state = S_FEED;
            end
            S_DONE:  if (start_rise) next_state = S_FEED;
            S_FAULT: if (ack_lvl && !estop_lvl) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        // E-stop overrides every other transition.
        if (estop_lvl && state != S_FAULT) next_state = S_FAULT;
    end

    // A piece only counts when its dwell finishes without being aborted.
    assign count_inc = (state == S_DWELL) && dwell_last && (next_state != S_FAULT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            dwell_cnt    <= '0;
            jam_cnt      <= '0;
            stop_pending <= 1'b0;
            piece_count  <= '0;
            belt_run     <= 1'b0;
            station_en   <= 1'b0;
            batch_done   <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state <= next_state;

            if (state == S_DWELL && next_state == S_DWELL) begin
                dwell_cnt    <= dwell_cnt + 16'd1;
                stop_pending <= stop_pending | stop_lvl;
            end else begin
                dwell_cnt    <= '0;
                stop_pending <= 1'b0;
            end

            if (next_state == state && belt_on(state)) jam_cnt <= jam_cnt + 24'd1;
            else                                       jam_cnt <= '0;

            if (state == S_DONE && next_state == S_FEED)    piece_count <= '0;
            else if (count_inc && piece_count != BATCH_C)   piece_count <= piece_count + CNT_W'(1);

            belt_run   <= belt_on(next_state);
            station_en <= (next_state == S_DWELL);
            batch_done <= (next_state == S_DONE);
            fault      <= (next_state == S_FAULT);
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_conveyor_sequencer.sv
// Directed bench for conveyor_sequencer with DWELL_CYCLES=4, JAM_CYCLES=20, BATCH=3.
module tb_conveyor_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, stop_req, estop, piece_sensor, fault_ack;
    logic       belt_run, station_en, batch_done, fault;
    logic [7:0] piece_count;
    logic [2:0] state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [2:0] IDLE = 3'd0, FEED = 3'd1, DWELL = 3'd2,
                           REL  = 3'd3, DONE = 3'd4, FLT  = 3'd5;

    conveyor_sequencer #(
        .DWELL_CYCLES(16'd4), .JAM_CYCLES(24'd20), .BATCH(8'd3), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop_req(stop_req), .estop(estop),
        .piece_sensor(piece_sensor), .fault_ack(fault_ack), .belt_run(belt_run),
        .station_en(station_en), .piece_count(piece_count), .batch_done(batch_done),
        .fault(fault), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start, stop_req, estop, piece, ack;
        int         wait_n;
        logic [2:0] st;
        logic       belt, stn, done, flt;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic sp, input logic es, input logic pc,
                       input logic ak, input int w, input logic [2:0] st,
                       input logic b, input logic sn, input logic d, input logic f,
                       input logic [7:0] c);
        vec_t v;
        v.start = s; v.stop_req = sp; v.estop = es; v.piece = pc; v.ack = ak;
        v.wait_n = w; v.st = st; v.belt = b; v.stn = sn; v.done = d; v.flt = f; v.cnt = c;
        vecs.push_back(v);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [2:0] st, input logic b,
                         input logic sn, input logic d, input logic f, input logic [7:0] c);
        logic [14:0] got, exp;
        got = {state_dbg, belt_run, station_en, batch_done, fault, piece_count};
        exp = {st, b, sn, d, f, c};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got state=%0d belt=%b stn=%b done=%b fault=%b cnt=%0d, expected state=%0d belt=%b stn=%b done=%b fault=%b cnt=%0d",
                     name, state_dbg, belt_run, station_en, batch_done, fault, piece_count,
                     st, b, sn, d, f, c);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0; stop_req = 1'b0; estop = 1'b0; piece_sensor = 1'b0; fault_ack = 1'b0;
        #12;
        check("reset_state", IDLE, 0, 0, 0, 0, 8'd0);
        #11 reset = 1'b0;

        // start sp es pc ak wait  state belt stn done flt cnt
        add(0, 0, 0, 0, 0, 2, IDLE,  0, 0, 0, 0, 8'd0);
        add(1, 0, 0, 0, 0, 2, IDLE,  0, 0, 0, 0, 8'd0);
        add(1, 0, 0, 0, 0, 1, FEED,  1, 0, 0, 0, 8'd0);
        add(0, 0, 0, 0, 0, 3, FEED,  1, 0, 0, 0, 8'd0);
        add(0, 0, 0, 1, 0, 2, FEED,  1, 0, 0, 0, 8'd0);
        add(0, 0, 0, 1, 0, 1, DWELL, 0, 1, 0, 0, 8'd0);
        add(0, 0, 0, 1, 0, 3, DWELL, 0, 1, 0, 0, 8'd0);
        add(0, 0, 0, 1, 0, 1, REL,   1, 0, 0, 0, 8'd1);
        add(0, 0, 0, 0, 0, 2, REL,   1, 0, 0, 0, 8'd1);
        add(0, 0, 0, 0, 0, 1, FEED,  1, 0, 0, 0, 8'd1);
        add(0, 0, 0, 1, 0, 2, FEED,  1, 0, 0, 0, 8'd1);
        add(0, 0, 0, 1, 0, 1, DWELL, 0, 1, 0, 0, 8'd1);
        add(0, 0, 0, 1, 0, 3, DWELL, 0, 1, 0, 0, 8'd1);
        add(0, 0, 0, 1, 0, 1, REL,   1, 0, 0, 0, 8'd2);
        add(0, 0, 0, 0, 0, 3, FEED,  1, 0, 0, 0, 8'd2);
        add(0, 0, 0, 1, 0, 3, DWELL, 0, 1, 0, 0, 8'd2);
        add(0, 0, 0, 1, 0, 3, DWELL, 0, 1, 0, 0, 8'd2);
        add(0, 0, 0, 1, 0, 1, DONE,  0, 0, 1, 0, 8'd3);
        add(0, 0, 0, 0, 0, 5, DONE,  0, 0, 1, 0, 8'd3);
        add(1, 0, 0, 0, 0, 3, FEED,  1, 0, 0, 0, 8'd0);
        add(0, 0, 0, 0, 0, 1, FEED,  1, 0, 0, 0, 8'd0);
        add(0, 1, 0, 0, 0, 2, FEED,  1, 0, 0, 0, 8'd0);
        add(0, 1, 0, 0, 0, 1, IDLE,  0, 0, 0, 0, 8'd0);
        add(0, 0, 0, 0, 0, 3, IDLE,  0, 0, 0, 0, 8'd0);

        foreach (vecs[i]) begin
            start = vecs[i].start; stop_req = vecs[i].stop_req; estop = vecs[i].estop;
            piece_sensor = vecs[i].piece; fault_ack = vecs[i].ack;
            step(vecs[i].wait_n);
            check($sformatf("vec%0d", i), vecs[i].st, vecs[i].belt, vecs[i].stn,
                  vecs[i].done, vecs[i].flt, vecs[i].cnt);
        end

        // Stop pulse at dwell start: dwell finishes, piece counted, then IDLE.
        start = 1'b1; step(3);
        check("stopdw_feed", FEED, 1, 0, 0, 0, 8'd0);
        start = 1'b0; piece_sensor = 1'b1; step(3);
        check("stopdw_dwell", DWELL, 0, 1, 0, 0, 8'd0);
        stop_req = 1'b1; step(1);
        stop_req = 1'b0; step(2);
        check("stopdw_still_dwell", DWELL, 0, 1, 0, 0, 8'd0);
        step(1);
        check("stopdw_idle", IDLE, 0, 0, 0, 0, 8'd1);
        piece_sensor = 1'b0; step(3);

        // Jam: no sensor activity for 20 cycles of FEED.
        start = 1'b1; step(3);
        check("jam_feed_entry", FEED, 1, 0, 0, 0, 8'd1);
        start = 1'b0; step(19);
        check("jam_feed_19", FEED, 1, 0, 0, 0, 8'd1);
        step(1);
        check("jam_fault_20", FLT, 0, 0, 0, 1, 8'd1);
        fault_ack = 1'b1; step(2);
        check("jam_ack_sync", FLT, 0, 0, 0, 1, 8'd1);
        step(1);
        check("jam_ack_idle", IDLE, 0, 0, 0, 0, 8'd1);
        fault_ack = 1'b0; step(3);

        // E-stop arriving with a sensor edge wins; ack ignored while e-stop held.
        start = 1'b1; step(3);
        check("es_feed", FEED, 1, 0, 0, 0, 8'd1);
        start = 1'b0; estop = 1'b1; piece_sensor = 1'b1; step(3);
        check("es_fault", FLT, 0, 0, 0, 1, 8'd1);
        fault_ack = 1'b1; step(4);
        check("es_ack_held", FLT, 0, 0, 0, 1, 8'd1);
        estop = 1'b0; step(2);
        check("es_release_sync", FLT, 0, 0, 0, 1, 8'd1);
        step(1);
        check("es_idle", IDLE, 0, 0, 0, 0, 8'd1);
        fault_ack = 1'b0; piece_sensor = 1'b0; step(3);

        // Async reset in the middle of a dwell.
        start = 1'b1; step(3);
        check("rst_feed", FEED, 1, 0, 0, 0, 8'd1);
        start = 1'b0; piece_sensor = 1'b1; step(3);
        check("rst_dwell", DWELL, 0, 1, 0, 0, 8'd1);
        #2 reset = 1'b1; piece_sensor = 1'b0;
        #1;
        check("rst_async_zero", IDLE, 0, 0, 0, 0, 8'd0);
        #3 reset = 1'b0;
        step(2);
        check("rst_after_idle", IDLE, 0, 0, 0, 0, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
